// File: rtl/io_main_dac_ramp_if.sv
// Sample/control bundle between the soft-start gain stage and its source.
// The source drives the master side; io_main_dac_ramp sits on the slave side.
interface io_main_dac_ramp_if;
    logic        enable;
    logic        dac_ready;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] dac_a;
    logic [15:0] dac_b;
    logic        ramp_busy;
    logic        running;

    modport master (
        output enable, dac_ready, in_valid, in_a, in_b,
        input  dac_a, dac_b, ramp_busy, running
    );

    modport slave (
        input  enable, dac_ready, in_valid, in_a, in_b,
        output dac_a, dac_b, ramp_busy, running
    );
endinterface

// File: rtl/io_main_dac_ramp.sv
// Soft-start/soft-stop gain stage for the DAC: both channels are scaled by a
// common gain that ramps linearly between zero and unity so outputs never step.
module io_main_dac_ramp #(
    parameter int GAIN_W   = 10,
    parameter int DIV_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    io_main_dac_ramp_if.slave bus
);

    localparam logic [GAIN_W:0] FULL_G = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] G_LAST = {1'b0, {GAIN_W{1'b1}}};
    localparam logic [GAIN_W:0] G_ONE  = {{GAIN_W{1'b0}}, 1'b1};
    localparam logic [GAIN_W:0] G_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t          state_reg;
    logic [GAIN_W:0] gain_reg;
    logic            tick;
    logic            in_ramp;

    assign in_ramp = (state_reg == RAMP_UP) || (state_reg == RAMP_DOWN);

    // Prescaler only advances while ramping; it reaches zero on every exit to
    // RUN/IDLE either by wrapping on the final tick or by the clear below.
    generate
        if (DIV_LOG2 == 0) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            logic [DIV_LOG2-1:0] presc_reg;

            always_ff @(posedge clk) begin
                if (rst || !bus.dac_ready || !in_ramp) begin
                    presc_reg <= '0;
                end else begin
                    presc_reg <= presc_reg + 1'b1;
                end
            end

            assign tick = &presc_reg;
        end
    endgenerate

    // Ramp controller. Losing dac_ready drops straight to zero gain: the DAC is
    // being reset, so there is nothing to ramp down into.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gain_reg  <= G_ZERO;
        end else if (!bus.dac_ready) begin
            state_reg <= IDLE;
            gain_reg  <= G_ZERO;
        end else begin
            case (state_reg)
                IDLE: begin
                    gain_reg <= G_ZERO;
                    if (bus.enable) begin
                        state_reg <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (!bus.enable) begin
                        state_reg <= RAMP_DOWN;
                    end else if (tick) begin
                        // >= guards a reversal that arrives already at unity
                        if (gain_reg >= G_LAST) begin
                            gain_reg  <= FULL_G;
                            state_reg <= RUN;
                        end else begin
                            gain_reg <= gain_reg + G_ONE;
                        end
                    end
                end
                RUN: begin
                    gain_reg <= FULL_G;
                    if (!bus.enable) begin
                        state_reg <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (bus.enable) begin
                        state_reg <= RAMP_UP;
                    end else if (tick) begin
                        if (gain_reg <= G_ONE) begin
                            gain_reg  <= G_ZERO;
                            state_reg <= IDLE;
                        end else begin
                            gain_reg <= gain_reg - G_ONE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gain_reg  <= G_ZERO;
                end
            endcase
        end
    end

    assign bus.ramp_busy = in_ramp;
    assign bus.running   = (state_reg == RUN);

    logic [15:0] in_ch  [2];
    logic [15:0] dac_ch [2];

    assign in_ch[0]  = bus.in_a;
    assign in_ch[1]  = bus.in_b;
    assign bus.dac_a = dac_ch[0];
    assign bus.dac_b = dac_ch[1];

    // Per-channel pipeline: hold -> product -> floor-shifted output.
    // With gain <= unity the shifted product always fits in 16 bits.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic signed [15:0]       hold_reg;
            logic signed [16+GAIN_W:0] prod_reg;
            logic [15:0]              dac_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg <= '0;
                    prod_reg <= '0;
                    dac_reg  <= '0;
                end else begin
                    if (bus.in_valid) begin
                        hold_reg <= in_ch[gi];
                    end
                    prod_reg <= hold_reg * $signed({1'b0, gain_reg});
                    dac_reg  <= 16'(prod_reg >>> GAIN_W);
                end
            end

            assign dac_ch[gi] = dac_reg;
        end
    endgenerate

endmodule
